// File: rtl/des_key_sched_if.sv
// Bundles the key-load request, the subkey valid/ready channel and the status flags
// that pass between the DES key scheduler and its loader/consumer.
interface des_key_sched_if;
    logic [63:0] key_in;
    logic        decrypt;
    logic        start;
    logic [47:0] subkey;
    logic        subkey_valid;
    logic        subkey_ready;
    logic [3:0]  round;
    logic        busy;
    logic        done;

    modport master (
        output key_in, decrypt, start, subkey_ready,
        input  subkey, subkey_valid, round, busy, done
    );

    modport slave (
        input  key_in, decrypt, start, subkey_ready,
        output subkey, subkey_valid, round, busy, done
    );
endinterface

// File: rtl/des_key_sched.sv
// Iterative DES round-key generator: one PC-2 subkey per valid/ready handshake,
// K1..K16 via left rotations or K16..K1 via right rotations, no stored key table.
module des_key_sched #(
    parameter int unsigned ROUNDS = 16
) (
    input  logic           clk,
    input  logic           rst,
    des_key_sched_if.slave bus
);
    localparam logic [3:0] LastRound = 4'(ROUNDS - 1);

    localparam int unsigned PC1 [56] = '{
        57, 49, 41, 33, 25, 17,  9,
         1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27,
        19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,
         7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29,
        21, 13,  5, 28, 20, 12,  4
    };

    localparam int unsigned PC2 [48] = '{
        14, 17, 11, 24,  1,  5,
         3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,
        16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,
        30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,
        46, 42, 50, 36, 29, 32
    };

    typedef enum logic [1:0] {StIdle, StIssue, StFin} state_e;

    state_e      state_q, state_d;
    logic [27:0] c_q, c_d, d_q, d_d;
    logic        dir_q, dir_d;
    logic [3:0]  round_q, round_d;
    logic [47:0] subkey_q, subkey_d;
    logic        valid_q, valid_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [55:0] cd0;
    logic        single;

    function automatic logic [55:0] pc1(input logic [63:0] k);
        logic [55:0] r;
        r = '0;
        for (int i = 0; i < 56; i++) r[6'(55 - i)] = k[6'(64 - PC1[i])];
        return r;
    endfunction

    function automatic logic [47:0] pc2(input logic [27:0] c, input logic [27:0] d);
        logic [55:0] cd;
        logic [47:0] r;
        cd = {c, d};
        r  = '0;
        for (int i = 0; i < 48; i++) r[6'(47 - i)] = cd[6'(56 - PC2[i])];
        return r;
    endfunction

    function automatic logic [27:0] rotl(input logic [27:0] x, input logic two);
        return two ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
    endfunction

    function automatic logic [27:0] rotr(input logic [27:0] x, input logic two);
        return two ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
    endfunction

    // Encrypt step S[r+2] and decrypt step S[16-r] coincide: single-bit at rounds 0, 7, 14.
    assign single = (round_q == 4'd0) || (round_q == 4'd7) || (round_q == 4'd14);
    assign cd0    = pc1(bus.key_in);

    always_comb begin
        state_d  = state_q;
        c_d      = c_q;
        d_d      = d_q;
        dir_d    = dir_q;
        round_d  = round_q;
        subkey_d = subkey_q;
        valid_d  = valid_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    dir_d    = bus.decrypt;
                    c_d      = bus.decrypt ? cd0[55:28] : rotl(cd0[55:28], 1'b0);
                    d_d      = bus.decrypt ? cd0[27:0]  : rotl(cd0[27:0], 1'b0);
                    subkey_d = pc2(c_d, d_d);
                    round_d  = 4'd0;
                    valid_d  = 1'b1;
                    busy_d   = 1'b1;
                    state_d  = StIssue;
                end
            end
            StIssue: begin
                if (valid_q && bus.subkey_ready) begin
                    if (round_q == LastRound) begin
                        valid_d = 1'b0;
                        done_d  = 1'b1;
                        state_d = StFin;
                    end else begin
                        round_d  = round_q + 4'd1;
                        c_d      = dir_q ? rotr(c_q, !single) : rotl(c_q, !single);
                        d_d      = dir_q ? rotr(d_q, !single) : rotl(d_q, !single);
                        subkey_d = pc2(c_d, d_d);
                    end
                end
            end
            StFin: begin
                busy_d  = 1'b0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            c_q      <= '0;
            d_q      <= '0;
            dir_q    <= 1'b0;
            round_q  <= '0;
            subkey_q <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            c_q      <= c_d;
            d_q      <= d_d;
            dir_q    <= dir_d;
            round_q  <= round_d;
            subkey_q <= subkey_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign bus.subkey       = subkey_q;
    assign bus.subkey_valid = valid_q;
    assign bus.round        = round_q;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
endmodule

// File: tb/tb_des_key_sched.sv
// Self-checking bench for des_key_sched: known-answer vectors, random keys with random
// backpressure against a cumulative-shift key-schedule model, and abort/ignore corner cases.
module tb_des_key_sched;
    localparam logic [63:0] KeyA = 64'h133457799BBCDFF1;

    localparam int unsigned PC1_T [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };
    localparam int unsigned PC2_T [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };
    localparam int SHIFTS [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    typedef struct {
        logic [63:0] key;
        logic        dec;
        int          idx;
        logic [47:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;
    logic [47:0] got [16];
    logic [3:0]  got_rnd [16];
    logic [47:0] saved [16];

    always #5 clk = ~clk;

    des_key_sched_if bus ();

    des_key_sched #(.ROUNDS(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [27:0] rot28(input logic [27:0] x, input int s);
        logic [27:0] r;
        r = (x << s) | (x >> (28 - s));
        return r;
    endfunction

    // DES key number n (1..16) computed from the cumulative left shift of C0/D0.
    function automatic logic [47:0] ref_key(input logic [63:0] key, input int n);
        logic [55:0] cd;
        logic [55:0] rcd;
        logic [47:0] k;
        int s;
        for (int i = 0; i < 56; i++) cd[6'(55 - i)] = key[6'(64 - PC1_T[i])];
        s = 0;
        for (int j = 0; j < n; j++) s += SHIFTS[j];
        rcd = {rot28(cd[55:28], s), rot28(cd[27:0], s)};
        for (int i = 0; i < 48; i++) k[6'(47 - i)] = rcd[6'(56 - PC2_T[i])];
        return k;
    endfunction

    // Called at a negedge; starts a sequence and collects accepted subkeys until done.
    task automatic run_seq(input logic [63:0] key, input logic dec, input int pct,
                           input int poke_cyc, output int n_got, output int done_cyc);
        int cyc;
        logic held;
        logic [47:0] hkey;
        logic [3:0] hrnd;
        bus.key_in       = key;
        bus.decrypt      = dec;
        bus.start        = 1'b1;
        bus.subkey_ready = 1'b0;
        n_got    = 0;
        done_cyc = -1;
        held     = 1'b0;
        @(negedge clk);
        cyc = 1;
        while (cyc < 300 && done_cyc < 0) begin
            bus.start   = (cyc == poke_cyc);
            bus.key_in  = (cyc == poke_cyc) ? ~key : {$urandom(), $urandom()};
            bus.decrypt = (cyc == poke_cyc) ? ~dec : 1'($urandom_range(1));
            if (cyc == 1) begin
                chk("busy_first", 64'(bus.busy), 64'd1);
                chk("valid_first", 64'(bus.subkey_valid), 64'd1);
            end
            if (bus.done) done_cyc = cyc;
            if (held) begin
                chk("hold_subkey", 64'(bus.subkey), 64'(hkey));
                chk("hold_round", 64'(bus.round), 64'(hrnd));
                chk("hold_valid", 64'(bus.subkey_valid), 64'd1);
            end
            held = 1'b0;
            if (bus.subkey_valid && n_got < 16) begin
                bus.subkey_ready = ($urandom_range(99) < pct);
                if (bus.subkey_ready) begin
                    got[n_got]     = bus.subkey;
                    got_rnd[n_got] = bus.round;
                    n_got++;
                end else begin
                    held = 1'b1;
                    hkey = bus.subkey;
                    hrnd = bus.round;
                end
            end else begin
                bus.subkey_ready = 1'($urandom_range(1));
            end
            @(negedge clk);
            cyc++;
        end
        bus.start = 1'b0;
    endtask

    task automatic check_run(input string name, input logic [63:0] key, input logic dec,
                             input int n_got, input int done_cyc, input logic full);
        chk({name, "_count"}, 64'(n_got), 64'd16);
        for (int i = 0; i < n_got && i < 16; i++) begin
            chk({name, "_subkey"}, 64'(got[i]), 64'(ref_key(key, dec ? 16 - i : i + 1)));
            chk({name, "_round"}, 64'(got_rnd[i]), 64'(i));
        end
        if (full) chk({name, "_done_cyc"}, 64'(done_cyc), 64'd17);
        else      chk({name, "_done_seen"}, 64'(done_cyc > 0), 64'd1);
        chk({name, "_busy_after"}, 64'(bus.busy), 64'd0);
        chk({name, "_done_after"}, 64'(bus.done), 64'd0);
        chk({name, "_valid_after"}, 64'(bus.subkey_valid), 64'd0);
    endtask

    initial begin
        vec_t vecs [8];
        int n, dc, t, ndone;
        logic [63:0] rk;
        logic rd;

        vecs[0] = '{key: KeyA, dec: 1'b0, idx: 0,  exp: 48'h1B02EFFC7072};
        vecs[1] = '{key: KeyA, dec: 1'b0, idx: 1,  exp: 48'h79AED9DBC9E5};
        vecs[2] = '{key: KeyA, dec: 1'b0, idx: 15, exp: 48'hCB3D8B0E17F5};
        vecs[3] = '{key: KeyA, dec: 1'b1, idx: 0,  exp: 48'hCB3D8B0E17F5};
        vecs[4] = '{key: KeyA, dec: 1'b1, idx: 14, exp: 48'h79AED9DBC9E5};
        vecs[5] = '{key: KeyA, dec: 1'b1, idx: 15, exp: 48'h1B02EFFC7072};
        vecs[6] = '{key: KeyA ^ 64'h0101010101010101, dec: 1'b0, idx: 0,  exp: 48'h1B02EFFC7072};
        vecs[7] = '{key: KeyA ^ 64'h0101010101010101, dec: 1'b0, idx: 15, exp: 48'hCB3D8B0E17F5};

        rst = 1'b1;
        bus.key_in = '0;
        bus.decrypt = 1'b0;
        bus.start = 1'b0;
        bus.subkey_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_valid", 64'(bus.subkey_valid), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);
        chk("rst_subkey", 64'(bus.subkey), 64'd0);
        chk("rst_round", 64'(bus.round), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            run_seq(vecs[i].key, vecs[i].dec, 100, -1, n, dc);
            chk("kat_vector", 64'(got[vecs[i].idx]), 64'(vecs[i].exp));
            check_run("kat", vecs[i].key, vecs[i].dec, n, dc, 1'b1);
        end

        // Decrypt order must be the encrypt order reversed.
        run_seq(KeyA, 1'b0, 100, -1, n, dc);
        for (int i = 0; i < 16; i++) saved[i] = got[i];
        run_seq(KeyA, 1'b1, 100, -1, n, dc);
        for (int i = 0; i < 16; i++) chk("reverse", 64'(got[i]), 64'(saved[15 - i]));

        // Backpressure on the known key, then random keys/directions.
        run_seq(KeyA, 1'b0, 50, -1, n, dc);
        check_run("bp_keya", KeyA, 1'b0, n, dc, 1'b0);
        for (int i = 0; i < 6; i++) begin
            rk = {$urandom(), $urandom()};
            rd = 1'($urandom_range(1));
            run_seq(rk, rd, 60, -1, n, dc);
            check_run("random", rk, rd, n, dc, 1'b0);
        end

        // Start while busy is ignored; start in FIN ignored; start right after begins anew.
        run_seq(KeyA, 1'b0, 100, 5, n, dc);
        check_run("start_busy", KeyA, 1'b0, n, dc, 1'b1);
        run_seq(KeyA, 1'b1, 100, 17, n, dc);
        check_run("start_fin", KeyA, 1'b1, n, dc, 1'b1);
        rk = {$urandom(), $urandom()};
        run_seq(rk, 1'b0, 100, -1, n, dc);
        check_run("start_after_fin", rk, 1'b0, n, dc, 1'b1);

        // Reset at round 7 aborts without a done pulse.
        bus.key_in = KeyA;
        bus.decrypt = 1'b0;
        bus.start = 1'b1;
        bus.subkey_ready = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        t = 0;
        while (bus.round != 4'd7 && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("reach_round7", 64'(t < 50), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_valid", 64'(bus.subkey_valid), 64'd0);
        chk("abort_busy", 64'(bus.busy), 64'd0);
        chk("abort_subkey", 64'(bus.subkey), 64'd0);
        chk("abort_round", 64'(bus.round), 64'd0);
        chk("abort_done", 64'(bus.done), 64'd0);
        ndone = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.done) ndone++;
        end
        chk("abort_no_done", 64'(ndone), 64'd0);
        bus.subkey_ready = 1'b0;
        run_seq(KeyA, 1'b0, 100, -1, n, dc);
        check_run("after_abort", KeyA, 1'b0, n, dc, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/des_key_sched.md
Name: des_key_sched

Overview:
Iterative DES round-key generator feeding the f-block (expansion/XOR/S-box path) one 48-bit subkey per round.
- Encrypt direction issues K1..K16 using left rotations.
- Decrypt direction issues K16..K1 using right rotations, with no stored table.
- Valid/ready handshake toward the round datapath; one subkey accepted per handshake.

Parameters:
- ROUNDS, 16, number of subkeys issued per key load; fixed at 16 for DES, other values unsupported.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- key_in  in  64  DES key; DES bit 1 = key_in[63]; parity bits (DES bits 8,16,…,64) ignored
- decrypt  in  1  0 = encrypt order K1..K16; 1 = decrypt order K16..K1; sampled with start
- start  in  1  load key_in and begin; honoured only in IDLE
- subkey  out  48  current subkey after PC-2; DES bit 1 = subkey[47], so subkey[47:42] feeds S1
- subkey_valid  out  1  subkey is presented
- subkey_ready  in  1  consumer accepts subkey when high with subkey_valid
- round  out  4  index of the presented subkey, 0..15 = issue order (not DES key number)
- busy  out  1  high from the cycle after start until done
- done  out  1  one-cycle pulse after the 16th handshake

Behaviour:
- Reset: state=IDLE; C,D=0; subkey=0; subkey_valid=0; round=0; busy=0; done=0. Reset mid-sequence aborts immediately with no done pulse.
- States: IDLE, ISSUE, FIN.
- IDLE, start=1 at edge T:
  - PC-1 applied to key_in, giving C0/D0 (28b each). dir latched from decrypt.
  - Encrypt: C,D <= rotl(C0,D0,1). Decrypt: C,D <= C0,D0 (no rotation).
  - round<=0; subkey_valid<=1; busy<=1; state<=ISSUE.
  - subkey=PC-2(C,D) is registered, so the first subkey is valid in the cycle after T (latency 1).
- Shift schedule S[1..16] = 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
- ISSUE, subkey_valid & subkey_ready at edge with round=r:
  - r<15: round<=r+1. Encrypt: rotl by S[r+2]. Decrypt: rotr by S[16-r]. New subkey valid the next cycle, so back-to-back handshakes run at one per cycle.
  - r=15: subkey_valid<=0; state<=FIN.
- ISSUE with subkey_ready=0: subkey, round, C and D hold stable; valid does not drop.
- FIN: done=1 for exactly one cycle; busy<=0; state<=IDLE; subkey keeps its last value.
- start while busy: ignored. key_in and decrypt changes while busy: no effect.
- start in the FIN cycle: ignored. A new start is accepted from the following cycle.
- Rotations are within each 28-bit half independently. Cumulative shift over 16 rounds is 28, so decrypt K16 = PC-2(C0,D0).
- PC-1 and PC-2 use the FIPS 46-3 tables with 1-based MSB-first indexing.
- Purely registered outputs; no combinational path from subkey_ready to any output.

Test Plan:
- Encrypt, key 0x133457799BBCDFF1, start, subkey_ready held high -> round0 subkey=0x1B02EFFC7072, round1=0x79AED9DBC9E5, round15=0xCB3D8B0E17F5; done pulse 17 cycles after start; busy low after done.
- Same key, decrypt=1 -> round0=0xCB3D8B0E17F5, round14=0x79AED9DBC9E5, round15=0x1B02EFFC7072; the full sequence equals the encrypt sequence reversed.
- Backpressure: subkey_ready toggled randomly in encrypt mode -> subkey and round stable while ready=0; exactly 16 accepted keys, matching the first test.
- start pulsed while busy with a different key/decrypt -> ignored, sequence unchanged; start in FIN cycle ignored; start one cycle later begins a new sequence.
- rst asserted at round 7 -> next cycle subkey_valid=0, busy=0, subkey=0, no done pulse; a subsequent start yields a correct full sequence.
- Parity-bit invariance: key 0x133457799BBCDFF1 XOR 0x0101010101010101 -> identical 16 subkeys to the first test.
